counter_mod: RTL and testbench

COUNTER_MOD -- requirements
Module: counter_mod

---
 rtl/counter_mod.sv | 92 +++++++++
 tb/tb_counter_mod.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// Modulo-(MOD_MAX+1) up/down counter with clear, clamped load, terminal pulse and one-shot stop.
// Define COUNTER_MOD_PRESCALE_EN to divide enabled cycles by PRESCALE before each count step.
module counter_mod #(
    parameter int WIDTH    = 6,
    parameter int MOD_MAX  = 59,
    parameter int ONE_SHOT = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_MAX);

    // Out-of-range configurations elaborate an empty marker block, visible in the hierarchy.
    if ((64'(MOD_MAX) > ((64'd1 << WIDTH) - 64'd1)) || (PRESCALE < 1)) begin : g_cfg_invalid
    end

    logic             step;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             done_nxt;
    logic             term;

`ifdef COUNTER_MOD_PRESCALE_EN
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps;
    logic          ps_wrap;

    assign ps_wrap = (ps == PS_LAST);
    assign step    = cnt_en && !done && ps_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ps <= '0;
        else if (clr || load)
            ps <= '0;
        else if (cnt_en && !done)
            ps <= ps_wrap ? '0 : ps + 1'b1;
    end
`else
    assign step = cnt_en && !done;
`endif

    assign term = up_dn ? (cnt == MAX) : (cnt == '0);

    always_comb begin
        cnt_nxt  = cnt;
        tc_nxt   = 1'b0;
        done_nxt = done;
        if (clr) begin
            cnt_nxt  = '0;
            done_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt  = (load_val > MAX) ? MAX : load_val;
            done_nxt = 1'b0;
        end else if (step) begin
            if (term) begin
                tc_nxt = 1'b1;
                if (ONE_SHOT != 0)
                    done_nxt = 1'b1;
                else
                    cnt_nxt = up_dn ? '0 : MAX;
            end else begin
                cnt_nxt = up_dn ? cnt + 1'b1 : cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tc   <= tc_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: free-run, one-shot and prescaled instances share stimulus.
module tb_counter_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [5:0] load_val;

    logic [5:0] cnt_a, cnt_b, cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       done_a, done_b, done_c;

    int n_chk = 0;
    int n_bad = 0;

`ifdef COUNTER_MOD_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(6), .MOD_MAX(59), .ONE_SHOT(0), .PRESCALE(1)) u_free (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt_a), .tc(tc_a), .done(done_a));

    counter_mod #(.WIDTH(6), .MOD_MAX(59), .ONE_SHOT(1), .PRESCALE(1)) u_oneshot (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt_b), .tc(tc_b), .done(done_b));

    counter_mod #(.WIDTH(6), .MOD_MAX(59), .ONE_SHOT(0), .PRESCALE(4)) u_pscl (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt_c), .tc(tc_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en_cnt;
        rst = 1'b0; cnt_en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        #2;
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_tc", 32'(tc_a), 0);
        chk("rst_done", 32'(done_b), 0);
        tick();
        rst = 1'b1; cnt_en = 1'b1; up_dn = 1'b1;

        // Free-run up: 1..59, then wrap to 0 with tc
        for (int i = 1; i <= 59; i++) begin
            tick();
            chk("up_cnt", 32'(cnt_a), 32'(i));
            chk("up_tc", 32'(tc_a), 0);
        end
        tick();
        chk("wrap_cnt", 32'(cnt_a), 0);
        chk("wrap_tc", 32'(tc_a), 1);
        tick();
        chk("post_wrap_cnt", 32'(cnt_a), 1);
        chk("post_wrap_tc", 32'(tc_a), 0);

        // Down from 0 wraps to MOD_MAX
        clr = 1'b1; tick();
        chk("clr_cnt", 32'(cnt_a), 0);
        clr = 1'b0; up_dn = 1'b0; tick();
        chk("dn_wrap_cnt", 32'(cnt_a), 59);
        chk("dn_wrap_tc", 32'(tc_a), 1);
        tick();
        chk("dn_cnt", 32'(cnt_a), 58);
        chk("dn_tc", 32'(tc_a), 0);
        cnt_en = 1'b0; tick();
        chk("hold_cnt", 32'(cnt_a), 58);
        chk("hold_tc", 32'(tc_a), 0);

        // Load clamp and clr-over-load priority
        load = 1'b1; load_val = 6'd63; tick();
        chk("clamp_cnt", 32'(cnt_a), 59);
        clr = 1'b1; load_val = 6'd20; tick();
        chk("clr_over_load", 32'(cnt_a), 0);
        clr = 1'b0;

        // One-shot stop at terminal
        load_val = 6'd57; tick();
        chk("os_load", 32'(cnt_b), 57);
        load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
        tick();
        chk("os_c1", 32'(cnt_b), 58);
        tick();
        chk("os_c2", 32'(cnt_b), 59);
        chk("os_c2_tc", 32'(tc_b), 0);
        tick();
        chk("os_c3", 32'(cnt_b), 59);
        chk("os_c3_tc", 32'(tc_b), 1);
        chk("os_c3_done", 32'(done_b), 1);
        tick();
        chk("os_stop_cnt", 32'(cnt_b), 59);
        chk("os_stop_tc", 32'(tc_b), 0);
        chk("os_stop_done", 32'(done_b), 1);
        load = 1'b1; load_val = 6'd10; tick();
        chk("os_reload_cnt", 32'(cnt_b), 10);
        chk("os_reload_done", 32'(done_b), 0);
        load = 1'b0;

        // Async reset mid-count at 30
        clr = 1'b1; tick();
        clr = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("pre_rst_cnt", 32'(cnt_a), 30);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(cnt_a), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_release_cnt", 32'(cnt_a), 1);

        // Prescaled instance: step every DIV enabled cycles, phase kept across cnt_en=0
        clr = 1'b1; tick();
        clr = 1'b0; en_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(); en_cnt++;
            chk("ps_cnt", 32'(cnt_c), 32'(en_cnt / DIV));
        end
        chk("ps_12", 32'(cnt_c), 32'(12 / DIV));
        for (int i = 0; i < 2; i++) begin tick(); en_cnt++; end
        cnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ps_hold", 32'(cnt_c), 32'(en_cnt / DIV));
        end
        cnt_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); en_cnt++;
            chk("ps_resume", 32'(cnt_c), 32'(en_cnt / DIV));
            chk("ps_tc", 32'(tc_c), 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
